// File: rtl/shop_db_ctrl.sv
// Table-backed shop command front end: one ASCII token in, one ASCII response out.
// Optional feature macro: SHOP_ABORT_EN ("Abort" cancels any pending dialogue).
module shop_db_ctrl #(
    parameter int TOK_CHARS  = 9,
    parameter int MAX_USERS  = 4,
    parameter int MAX_ITEMS  = 8,
    parameter int STOCK_BITS = 8,
    parameter logic [TOK_CHARS*8-1:0] ADMIN_NAME = (TOK_CHARS*8)'("Adm"),
    parameter logic [TOK_CHARS*8-1:0] ADMIN_PASS = (TOK_CHARS*8)'("Pw0")
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_rdy,
    input  logic [TOK_CHARS*8-1:0]  i_a,
    input  logic [STOCK_BITS-1:0]   i_u,
    output logic [71:0]             o_a,
    output logic                    o_vld,
    output logic [2:0]              o_dbg_state
);
    localparam int TW  = TOK_CHARS * 8;
    localparam int UIW = (MAX_USERS > 1) ? $clog2(MAX_USERS) : 1;
    localparam int IIW = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;

    localparam logic [TW-1:0] K_LOGIN   = TW'("Login");
    localparam logic [TW-1:0] K_LOGOUT  = TW'("Logout");
    localparam logic [TW-1:0] K_ADDUSR  = TW'("AddUsr");
    localparam logic [TW-1:0] K_DELUSR  = TW'("DelUsr");
    localparam logic [TW-1:0] K_ADDITEM = TW'("AddItem");
    localparam logic [TW-1:0] K_DELITEM = TW'("DelItem");
    localparam logic [TW-1:0] K_BUY     = TW'("Buy");
`ifdef SHOP_ABORT_EN
    localparam logic [TW-1:0] K_ABORT   = TW'("Abort");
`endif

    typedef enum logic [2:0] {
        S_CMD, S_USERNAME, S_PASSWORD, S_ITEM_NAME, S_ITEM_STOCK
    } state_t;
    typedef enum logic [2:0] {
        C_LOGIN, C_ADDUSR, C_DELUSR, C_ADDITEM, C_DELITEM, C_BUY
    } cmd_t;

    state_t state;
    cmd_t   cmd_q;
    logic   logged_in;
    logic [UIW-1:0] cur_user, sel_user;
    logic [TW-1:0]  new_name;

    logic [TW-1:0]         user_name [MAX_USERS];
    logic [TW-1:0]         user_pass [MAX_USERS];
    logic [MAX_USERS-1:0]  user_vld, user_adm;
    logic [TW-1:0]         item_name  [MAX_ITEMS];
    logic [STOCK_BITS-1:0] item_stock [MAX_ITEMS];
    logic [UIW-1:0]        item_owner [MAX_ITEMS];
    logic [MAX_ITEMS-1:0]  item_vld;

    logic u_hit, u_free, i_hit, i_free, is_admin;
    logic [UIW-1:0] u_hit_idx, u_free_idx;
    logic [IIW-1:0] i_hit_idx, i_free_idx;

    assign o_dbg_state = state;
    assign is_admin    = logged_in && user_adm[cur_user];

    // Descending scan so the lowest matching / free slot wins.
    always_comb begin
        u_hit = 1'b0; u_hit_idx = '0; u_free = 1'b0; u_free_idx = '0;
        i_hit = 1'b0; i_hit_idx = '0; i_free = 1'b0; i_free_idx = '0;
        for (int i = MAX_USERS - 1; i >= 0; i--) begin
            if (user_vld[i] && i_a != '0 && user_name[i] == i_a) begin
                u_hit = 1'b1; u_hit_idx = UIW'(i);
            end
            if (!user_vld[i]) begin
                u_free = 1'b1; u_free_idx = UIW'(i);
            end
        end
        for (int i = MAX_ITEMS - 1; i >= 0; i--) begin
            if (item_vld[i] && i_a != '0 && item_name[i] == i_a) begin
                i_hit = 1'b1; i_hit_idx = IIW'(i);
            end
            if (!item_vld[i]) begin
                i_free = 1'b1; i_free_idx = IIW'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= S_CMD;
            cmd_q     <= C_LOGIN;
            logged_in <= 1'b0;
            cur_user  <= '0;
            sel_user  <= '0;
            new_name  <= '0;
            o_a       <= 72'("Cmd?");
            o_vld     <= 1'b0;
            user_vld  <= '0;
            user_adm  <= '0;
            item_vld  <= '0;
            for (int i = 0; i < MAX_USERS; i++) begin
                user_name[i] <= '0;
                user_pass[i] <= '0;
            end
            for (int i = 0; i < MAX_ITEMS; i++) begin
                item_name[i]  <= '0;
                item_stock[i] <= '0;
                item_owner[i] <= '0;
            end
            user_name[0] <= ADMIN_NAME;
            user_pass[0] <= ADMIN_PASS;
            user_vld[0]  <= 1'b1;
            user_adm[0]  <= 1'b1;
        end else begin
            o_vld <= i_rdy;
            if (i_rdy) begin
`ifdef SHOP_ABORT_EN
                if (state != S_CMD && i_a == K_ABORT) begin
                    o_a   <= 72'("Aborted");
                    state <= S_CMD;
                end else
`endif
                begin
                    case (state)
                        S_CMD: begin
                            if (i_a == K_LOGIN) begin
                                if (logged_in) o_a <= 72'("InvalPerm");
                                else begin
                                    o_a <= 72'("Usrname?"); cmd_q <= C_LOGIN; state <= S_USERNAME;
                                end
                            end else if (i_a == K_LOGOUT) begin
                                if (logged_in) begin
                                    o_a <= 72'("LoggedOut"); logged_in <= 1'b0; cur_user <= '0;
                                end else o_a <= 72'("InvalPerm");
                            end else if (i_a == K_ADDUSR || i_a == K_DELUSR) begin
                                if (!is_admin) o_a <= 72'("InvalPerm");
                                else if (i_a == K_ADDUSR && !u_free) o_a <= 72'("UsrsFull");
                                else begin
                                    o_a   <= 72'("Usrname?");
                                    cmd_q <= (i_a == K_ADDUSR) ? C_ADDUSR : C_DELUSR;
                                    state <= S_USERNAME;
                                end
                            end else if (i_a == K_ADDITEM || i_a == K_DELITEM || i_a == K_BUY) begin
                                if (!logged_in) o_a <= 72'("InvalPerm");
                                else if (i_a == K_ADDITEM && !i_free) o_a <= 72'("ItmsFull");
                                else begin
                                    o_a <= 72'("ItmName?");
                                    if (i_a == K_ADDITEM)      cmd_q <= C_ADDITEM;
                                    else if (i_a == K_DELITEM) cmd_q <= C_DELITEM;
                                    else                       cmd_q <= C_BUY;
                                    state <= S_ITEM_NAME;
                                end
                            end else o_a <= 72'("InvalCmd");
                        end
                        S_USERNAME: begin
                            state <= S_CMD;
                            if (cmd_q == C_LOGIN) begin
                                if (!u_hit) o_a <= 72'("UsrUnknwn");
                                else begin
                                    sel_user <= u_hit_idx; o_a <= 72'("Passwd?"); state <= S_PASSWORD;
                                end
                            end else if (cmd_q == C_ADDUSR) begin
                                if (u_hit) o_a <= 72'("UsrTaken");
                                else begin
                                    new_name <= i_a; o_a <= 72'("Passwd?"); state <= S_PASSWORD;
                                end
                            end else if (i_a == ADMIN_NAME) o_a <= 72'("NoDelAdmn");
                            else if (!u_hit) o_a <= 72'("UsrUnknwn");
                            else begin
                                // Items owned by a deleted user go with it.
                                user_vld[u_hit_idx] <= 1'b0;
                                for (int j = 0; j < MAX_ITEMS; j++)
                                    if (item_owner[j] == u_hit_idx) item_vld[j] <= 1'b0;
                                o_a <= 72'("UsrDeletd");
                            end
                        end
                        S_PASSWORD: begin
                            state <= S_CMD;
                            if (cmd_q == C_LOGIN) begin
                                if (user_pass[sel_user] == i_a) begin
                                    logged_in <= 1'b1; cur_user <= sel_user; o_a <= 72'("LoggedIn");
                                end else o_a <= 72'("BadPass");
                            end else begin
                                user_vld[u_free_idx]  <= 1'b1;
                                user_adm[u_free_idx]  <= 1'b0;
                                user_name[u_free_idx] <= new_name;
                                user_pass[u_free_idx] <= i_a;
                                o_a <= 72'("UsrAdded");
                            end
                        end
                        S_ITEM_NAME: begin
                            state <= S_CMD;
                            if (cmd_q == C_ADDITEM) begin
                                if (i_hit) o_a <= 72'("ItmExists");
                                else begin
                                    new_name <= i_a; o_a <= 72'("Stock?"); state <= S_ITEM_STOCK;
                                end
                            end else if (!i_hit) o_a <= 72'("ItmUnknwn");
                            else if (cmd_q == C_DELITEM) begin
                                if (item_owner[i_hit_idx] != cur_user && !is_admin) o_a <= 72'("NtYourItm");
                                else begin
                                    item_vld[i_hit_idx] <= 1'b0; o_a <= 72'("ItmDeletd");
                                end
                            end else if (item_stock[i_hit_idx] == '0) o_a <= 72'("NoStock");
                            else begin
                                item_stock[i_hit_idx] <= item_stock[i_hit_idx] - STOCK_BITS'(1);
                                o_a <= 72'("ItmBought");
                            end
                        end
                        default: begin
                            item_vld[i_free_idx]   <= 1'b1;
                            item_name[i_free_idx]  <= new_name;
                            item_stock[i_free_idx] <= i_u;
                            item_owner[i_free_idx] <= cur_user;
                            o_a   <= 72'("ItmAdded");
                            state <= S_CMD;
                        end
                    endcase
                end
            end
        end
    end
endmodule
